button_debounce: RTL and testbench

Four-channel push-button input conditioner, the input-side counterpart to the LED driver logic. Each channel synchronises a raw asynchronous button pin into the `clk` domain and filters contact bounce. It produces a clean debounced level plus single-cycle press, release and long-hold event pulses for downstream control logic.

---
 rtl/button_debounce.sv | 181 ++++++++++++++++++
 tb/tb_button_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Four-channel push-button conditioner: sync, debounce, press/release/hold.
// Ports: clk, rst (sync low), btn1..4 in; state/press/release/hold 1..4 out.

module button_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic state,
  output logic press,
  output logic rls,
  output logic hold
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW =
    (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } st_t;

  st_t           st;
  st_t           st_n;
  logic          p;
  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_n;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_n;
  logic          lvl;
  logic          diff;
  logic          accept;
  logic          acc_p;
  logic          acc_r;
  logic          press_n;
  logic          rls_n;
  logic          hold_n;

  assign p     = ACTIVE_LOW ? ~pin : pin;
  assign lvl   = (st != IDLE);
  assign state = lvl;

  always_comb begin
    diff    = (s2 != lvl);
    accept  = diff && (dcnt == DMAX);
    acc_p   = accept & s2;
    acc_r   = accept & ~s2;
    dcnt_n  = (diff && !accept) ? dcnt + 1'b1 : '0;
    st_n    = st;
    hcnt_n  = hcnt;
    press_n = 1'b0;
    rls_n   = 1'b0;
    hold_n  = 1'b0;
    unique case (st)
      IDLE: begin
        if (acc_p) begin
          st_n    = PRESSED;
          press_n = 1'b1;
          hcnt_n  = '0;
        end
      end
      PRESSED: begin
        // a release on the threshold edge beats hold
        if (acc_r) begin
          st_n   = IDLE;
          rls_n  = 1'b1;
          hcnt_n = '0;
        end else if (hcnt == HMAX) begin
          st_n   = HELD;
          hold_n = 1'b1;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      HELD: begin
        if (acc_r) begin
          st_n   = IDLE;
          rls_n  = 1'b1;
          hcnt_n = '0;
        end
      end
      default: begin
        st_n   = IDLE;
        hcnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      st    <= IDLE;
      dcnt  <= '0;
      hcnt  <= '0;
      press <= 1'b0;
      rls   <= 1'b0;
      hold  <= 1'b0;
    end else begin
      s1    <= p;
      s2    <= s1;
      st    <= st_n;
      dcnt  <= dcnt_n;
      hcnt  <= hcnt_n;
      press <= press_n;
      rls   <= rls_n;
      hold  <= hold_n;
    end
  end

endmodule

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  input  logic btn4,
  output logic state1,
  output logic state2,
  output logic state3,
  output logic state4,
  output logic press1,
  output logic press2,
  output logic press3,
  output logic press4,
  output logic release1,
  output logic release2,
  output logic release3,
  output logic release4,
  output logic hold1,
  output logic hold2,
  output logic hold3,
  output logic hold4
);

  logic [3:0] pins;
  logic [3:0] st;
  logic [3:0] pr;
  logic [3:0] rl;
  logic [3:0] hd;

  assign pins = {btn4, btn3, btn2, btn1};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    button_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .pin  (pins[i]),
      .state(st[i]),
      .press(pr[i]),
      .rls  (rl[i]),
      .hold (hd[i])
    );
  end

  assign {state4, state3, state2, state1} = st;
  assign {press4, press3, press2, press1} = pr;
  assign {release4, release3, release2, release1} = rl;
  assign {hold4, hold3, hold2, hold1} = hd;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: event scoreboard of expected pulses.
// D=4, L=10, active-low pins; pulses compared by channel, kind, cycle.

module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 10;
  localparam int K_PR = 0;
  localparam int K_RL = 1;
  localparam int K_HD = 2;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn1 = 1'b1;
  logic btn2 = 1'b1;
  logic btn3 = 1'b1;
  logic btn4 = 1'b1;
  logic state1, state2, state3, state4;
  logic press1, press2, press3, press4;
  logic release1, release2, release3, release4;
  logic hold1, hold2, hold3, hold4;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  ev_t  q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn1    (btn1),
    .btn2    (btn2),
    .btn3    (btn3),
    .btn4    (btn4),
    .state1  (state1),
    .state2  (state2),
    .state3  (state3),
    .state4  (state4),
    .press1  (press1),
    .press2  (press2),
    .press3  (press3),
    .press4  (press4),
    .release1(release1),
    .release2(release2),
    .release3(release3),
    .release4(release4),
    .hold1   (hold1),
    .hold2   (hold2),
    .hold3   (hold3),
    .hold4   (hold4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input ev_t e);
    return e.ch * 1000000 + e.kind * 100000 + e.cyc;
  endfunction

  task automatic push(input int ch,
                      input int kind,
                      input int at);
    ev_t e;
    e.ch   = ch;
    e.kind = kind;
    e.cyc  = at;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] pv [3];
  always_comb begin
    pv[K_PR] = {press4, press3, press2, press1};
    pv[K_RL] = {release4, release3, release2, release1};
    pv[K_HD] = {hold4, hold3, hold2, hold1};
  end

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (pv[k][c] === 1'b1) begin
          ev_t o;
          o.ch   = c + 1;
          o.kind = k;
          o.cyc  = cyc;
          if (q.size() == 0) begin
            check("unexpected_pulse", enc(o), 0);
          end else begin
            check("pulse", enc(o), enc(q.pop_front()));
          end
        end
      end
    end
    if (q.size() > 0 && q[0].cyc < cyc) begin
      check("missed_pulse", 0, enc(q.pop_front()));
    end
  end

  function automatic int outs();
    return {28'd0, state4, state3, state2, state1} |
           ({28'd0, pv[K_PR]} << 4) |
           ({28'd0, pv[K_RL]} << 8) |
           ({28'd0, pv[K_HD]} << 12);
  endfunction

  initial begin
    int c;
    step(3);
    check("reset_outs", outs(), 0);
    rst = 1'b1;
    step(20);
    check("idle_outs", outs(), 0);

    c = cyc;
    btn1 = 1'b0;
    push(1, K_PR, c + 6);
    step(5);
    check("state1_before", int'(state1), 0);
    step(1);
    check("state1_press", int'(state1), 1);
    check("quiet_2to4",
          int'({state4, state3, state2}), 0);
    step(2);
    btn1 = 1'b1;
    push(1, K_RL, c + 14);
    step(6);
    check("state1_rel", int'(state1), 0);
    step(4);

    btn2 = 1'b0; step(3);
    btn2 = 1'b1; step(1);
    btn2 = 1'b0; step(2);
    btn2 = 1'b1; step(8);
    check("bounce_state2", int'(state2), 0);
    c = cyc;
    btn2 = 1'b0;
    push(2, K_PR, c + 6);
    step(8);
    check("state2_press", int'(state2), 1);
    btn2 = 1'b1;
    push(2, K_RL, c + 14);
    step(10);

    c = cyc;
    btn3 = 1'b0;
    push(3, K_PR, c + 6);
    push(3, K_HD, c + 16);
    step(30);
    check("state3_held", int'(state3), 1);
    btn3 = 1'b1;
    push(3, K_RL, c + 36);
    step(10);
    check("state3_rel", int'(state3), 0);

    c = cyc;
    btn4 = 1'b0;
    push(4, K_PR, c + 6);
    step(10);
    btn4 = 1'b1;
    push(4, K_RL, c + 16);
    step(12);
    check("state4_rel", int'(state4), 0);

    c = cyc;
    btn1 = 1'b0;
    btn2 = 1'b0;
    push(1, K_PR, c + 6);
    push(2, K_PR, c + 6);
    step(5);
    btn1 = 1'b1;
    btn2 = 1'b1;
    push(1, K_RL, c + 11);
    push(2, K_RL, c + 11);
    step(10);

    btn1 = 1'b0;
    step(2);
    rst = 1'b0;
    step(8);
    check("rst_mid_outs", outs(), 0);
    c = cyc;
    rst = 1'b1;
    push(1, K_PR, c + 6);
    step(8);
    check("state1_after_rst", int'(state1), 1);
    btn1 = 1'b1;
    push(1, K_RL, c + 14);
    step(12);

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
